message_scheduler: RTL and testbench

SHA-256 message-schedule generator: the producer side of the `Wt`/`STN` interface consumed by the compression core. It accepts one 512-bit padded block and holds the current schedule word `W[t]` stable on `Wt_out`. Each `STN` request from the compression core, relayed by the controller, makes it compute `W[t+16]` serially on a single shared 32-bit adder. On the falling edge of `STN` it advances to `W[t+1]`, until all 64 words have been served.

---
 rtl/message_scheduler_pkg.sv | 26 ++
 rtl/message_scheduler_adder.sv | 13 +
 rtl/message_scheduler.sv | 118 +++++++++++
 tb/tb_message_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/message_scheduler_pkg.sv
// Shared SHA-256 definitions for the message-schedule path: widths, the
// scheduler state encoding and the message-schedule sigma functions.
package message_scheduler_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int WIN_N   = 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_REQ  = 3'd1;
  localparam logic [2:0] S_CALC1     = 3'd2;
  localparam logic [2:0] S_CALC2     = 3'd3;
  localparam logic [2:0] S_CALC3     = 3'd4;
  localparam logic [2:0] S_WAIT_FALL = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  // Lower-case sigma variants used only by the message schedule.
  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/message_scheduler_adder.sv
// Shared 32-bit modulo-2^32 adder; the scheduler time-multiplexes it
// across its three calculation steps.
module adder_32bit
  import message_scheduler_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/message_scheduler.sv
// SHA-256 message-schedule generator: holds W[t] on Wt_out and computes
// W[t+16] serially on one adder for each STN request.
module message_scheduler
  import message_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic               STN,
  output logic [WORD_W-1:0]  Wt_out,
  output logic [5:0]         word_idx,
  output logic               busy,
  output logic               done
);

  logic [2:0]        state;
  logic [WORD_W-1:0] w [WIN_N];
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] nxt;
  logic              stn_d;
  logic              fall_pend;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic [WORD_W-1:0] sum;
  logic              rise;
  logic              fall;

  assign rise = STN & ~stn_d;
  assign fall = ~STN & stn_d;

  // Operand selection for the single adder, steered by the calculation step.
  always_comb begin
    // NOTE: defaults before the case keep this purely combinational (no latch).
    op_a = acc;
    op_b = '0;
    case (state)
      S_CALC1: begin
        op_a = w[0];
        op_b = w[9];
      end
      S_CALC2: op_b = sigma0(w[1]);
      S_CALC3: op_b = sigma1(w[14]);
      default: ;
    endcase
  end

  adder_32bit u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      nxt       <= '0;
      stn_d     <= 1'b0;
      fall_pend <= 1'b0;
      word_idx  <= '0;
      done      <= 1'b0;
      // NOTE: the window is sixteen flops, not a RAM, so it is reset so that
      // Wt_out reads zero straight out of reset.
      for (int i = 0; i < WIN_N; i++) w[i] <= '0;
    end else begin
      stn_d <= STN;
      done  <= (state == S_DONE);
      if (load) begin
        for (int i = 0; i < WIN_N; i++)
          w[i] <= block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
        word_idx  <= '0;
        acc       <= '0;
        fall_pend <= 1'b0;
        state     <= S_WAIT_REQ;
      end else begin
        case (state)
          S_WAIT_REQ: if (rise) state <= S_CALC1;
          S_CALC1: begin
            acc   <= sum;
            state <= S_CALC2;
            if (fall) fall_pend <= 1'b1;
          end
          S_CALC2: begin
            acc   <= sum;
            state <= S_CALC3;
            if (fall) fall_pend <= 1'b1;
          end
          S_CALC3: begin
            nxt   <= sum;
            state <= S_WAIT_FALL;
            if (fall) fall_pend <= 1'b1;
          end
          S_WAIT_FALL: begin
            // A short STN pulse has already fallen; commit without waiting.
            if (fall || fall_pend) begin
              fall_pend <= 1'b0;
              if (word_idx == 6'd63) begin
                state <= S_DONE;
              end else begin
                for (int i = 0; i < WIN_N-1; i++) w[i] <= w[i+1];
                w[WIN_N-1] <= nxt;
                word_idx   <= word_idx + 6'd1;
                state      <= S_WAIT_REQ;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign Wt_out = w[0];
  assign busy   = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_message_scheduler.sv
// Directed bench for message_scheduler: "abc" block schedule words, STN
// handshake timing, done pulse, load abort and asynchronous reset.
module tb_message_scheduler;

  typedef logic [31:0] sched_t [64];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [511:0] block_in;
  logic         STN;
  logic [31:0]  Wt_out;
  logic [5:0]   word_idx;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  sched_t       w_nom;
  sched_t       w_short;
  logic [31:0]  tmp;
  logic [255:0] dig;

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 416'h0, 32'h00000000, 32'h00000018};
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  message_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .block_in (block_in),
    .STN      (STN),
    .Wt_out   (Wt_out),
    .word_idx (word_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // One STN request: record the word the core would read, hold STN high, drop it.
  task automatic pulse(input int hi, input int lo, output logic [31:0] seen);
    seen = Wt_out;
    STN  = 1'b1;
    repeat (hi) step();
    STN  = 1'b0;
    repeat (lo) step();
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 compression of one block's schedule from the standard IV.
  task automatic digest_of(input sched_t ws, output logic [255:0] d);
    logic [31:0] h0 [8];
    logic [31:0] a, b, c, e, f, g, h, dd, t1, t2;
    h0 = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    a = h0[0]; b = h0[1]; c = h0[2]; dd = h0[3];
    e = h0[4]; f = h0[5]; g = h0[6]; h = h0[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[t] + ws[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = dd + t1;
      dd = c; c = b; b = a; a = t1 + t2;
    end
    d = {a + h0[0], b + h0[1], c + h0[2], dd + h0[3],
         e + h0[4], f + h0[5], g + h0[6], h + h0[7]};
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    STN      = 1'b0;
    block_in = ABC_BLOCK;
    step();
    step();
    check("rst_wt",   Wt_out,   32'h0);
    check("rst_idx",  word_idx, 6'd0);
    check("rst_busy", busy,     1'b0);
    check("rst_done", done,     1'b0);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 1'b0);

    // Nominal run: 4-cycle-high STN, period 6.
    do_load();
    check("load_w0",   Wt_out,   32'h61626380);
    check("load_idx",  word_idx, 6'd0);
    check("load_busy", busy,     1'b1);

    w_nom[0] = Wt_out;
    STN = 1'b1;
    repeat (4) step();
    STN = 1'b0;
    check("nom_stable_at_fall", Wt_out, 32'h61626380);
    step();
    check("nom_w1",   Wt_out,   32'h0);
    check("nom_idx1", word_idx, 6'd1);
    step();
    for (int t = 1; t < 64; t++) pulse(4, (t == 63) ? 0 : 2, w_nom[t]);
    check("nom_done_at_fall", done, 1'b0);
    step();
    check("nom_busy_low", busy,     1'b0);
    check("nom_done_f1",  done,     1'b0);
    check("nom_idx63",    word_idx, 6'd63);
    step();
    check("nom_done_f2",  done,     1'b1);
    step();
    check("nom_done_f3",  done,     1'b0);
    check("nom_done_cnt", done_cnt, 1);
    check("nom_w16", w_nom[16], 32'h61626380);
    check("nom_w17", w_nom[17], 32'h000F0000);
    check("nom_w18", w_nom[18], 32'h7DA86405);
    digest_of(w_nom, dig);
    check("nom_digest", dig, ABC_DIGEST);

    // Short STN (2 cycles high): fall is latched during the calculation.
    do_load();
    w_short[0] = Wt_out;
    STN = 1'b1;
    repeat (2) step();
    STN = 1'b0;
    step();
    step();
    check("short_stable", Wt_out, 32'h61626380);
    step();
    check("short_w1",   Wt_out,   32'h0);
    check("short_idx1", word_idx, 6'd1);
    step();
    for (int t = 1; t < 64; t++) pulse(2, (t == 63) ? 0 : 4, w_short[t]);
    repeat (6) step();
    check("short_busy_low", busy,     1'b0);
    check("short_done_cnt", done_cnt, 2);
    check("short_w17",      w_short[17], 32'h000F0000);
    digest_of(w_short, dig);
    check("short_digest", dig, ABC_DIGEST);

    // Load abort at word_idx 20, landing in the middle of a calculation.
    do_load();
    for (int t = 0; t < 20; t++) pulse(4, 2, tmp);
    check("abort_idx20", word_idx, 6'd20);
    STN = 1'b1;
    step();
    load = 1'b1;
    step();
    load = 1'b0;
    STN  = 1'b0;
    check("abort_w0",   Wt_out,   32'h61626380);
    check("abort_idx0", word_idx, 6'd0);
    check("abort_busy", busy,     1'b1);
    step();
    step();
    pulse(4, 2, tmp);
    check("abort_w1",   Wt_out,   32'h0);
    check("abort_idx1", word_idx, 6'd1);

    // Asynchronous reset at word_idx 30, mid-cycle.
    for (int t = 1; t < 30; t++) pulse(4, 2, tmp);
    check("pre_rst_idx30", word_idx, 6'd30);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wt",   Wt_out,   32'h0);
    check("async_rst_idx",  word_idx, 6'd0);
    check("async_rst_busy", busy,     1'b0);
    check("async_rst_done", done,     1'b0);
    step();
    rst_n = 1'b1;
    step();
    pulse(4, 2, tmp);
    check("idle_stn_idx",  word_idx, 6'd0);
    check("idle_stn_busy", busy,     1'b0);
    check("idle_stn_wt",   Wt_out,   32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
